wash_dispatcher: RTL and testbench

Laundromat front-end scheduler that shares a bank of washer controllers between several payment kiosks. Kiosk wash orders (single or double wash) are arbitrated round-robin into an order queue. Queued orders are dispatched to free, enabled machines as a one-cycle coin_in pulse plus a held double_wash level. Per-machine busy is tracked from each washer's wash_done.

---
 rtl/wash_dispatcher.sv | 164 ++++++++++++++++
 tb/tb_wash_dispatcher.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_dispatcher.sv
// Shares a bank of washer controllers between payment kiosks: round-robin order intake
// into a small queue, then one-at-a-time dispatch to free, enabled machines.
//
// state   | meaning
// D_IDLE  | waiting for a queued order and a free machine
// D_ISSUE | coin pulse and ack driven for the latched machine/order
// D_GAP   | one idle cycle before the next dispatch
module wash_dispatcher #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_MACH = 4,
  parameter int QDEPTH   = 4,
  parameter int REQ_W    = $clog2(NUM_REQ),
  parameter int MACH_W   = $clog2(NUM_MACH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_double,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_MACH-1:0]     mach_wash_done,
  input  logic [NUM_MACH-1:0]     mach_disable,
  output logic [NUM_MACH-1:0]     mach_coin,
  output logic [NUM_MACH-1:0]     mach_double,
  output logic [NUM_MACH-1:0]     mach_busy,
  output logic                    ack_valid,
  output logic [REQ_W-1:0]        ack_req_id,
  output logic [MACH_W-1:0]       ack_mach_id,
  output logic [$clog2(QDEPTH):0] queue_count
);

  localparam int QW = $clog2(QDEPTH);
  localparam logic [QW:0] QFULL = (QW+1)'(QDEPTH);

  typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_GAP} state_t;

  state_t              state;
  logic [REQ_W-1:0]    rr_req;
  logic [REQ_W-1:0]    grant_idx;
  logic [REQ_W-1:0]    cand_req;
  logic                grant_found;
  logic [MACH_W-1:0]   rr_mach;
  logic [MACH_W-1:0]   sel_idx;
  logic [MACH_W-1:0]   cand_mach;
  logic [MACH_W-1:0]   sel_q;
  logic                sel_found;
  logic [NUM_MACH-1:0] mach_free;
  logic [REQ_W:0]      q_mem [QDEPTH];
  logic [QW-1:0]       wr_ptr;
  logic [QW-1:0]       rd_ptr;
  logic [REQ_W:0]      head;
  logic                push;
  logic                pop;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_req    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_req = REQ_W'((int'(rr_req) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand_req]) begin
        grant_found = 1'b1;
        grant_idx   = cand_req;
      end
    end
  end

  // Fullness is judged on the current count only; a same-cycle pop does not open a slot.
  always_comb begin
    req_ready = '0;
    if (grant_found && (queue_count != QFULL))
      req_ready[grant_idx] = 1'b1;
  end

  assign push      = |(req_valid & req_ready);
  assign pop       = (state == D_ISSUE);
  assign mach_free = ~mach_busy & ~mach_disable;
  assign head      = q_mem[rd_ptr];

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_mach = '0;
    for (int k = 0; k < NUM_MACH; k++) begin
      cand_mach = MACH_W'((int'(rr_mach) + k) % NUM_MACH);
      if (!sel_found && mach_free[cand_mach]) begin
        sel_found = 1'b1;
        sel_idx   = cand_mach;
      end
    end
  end

  // Entries are {kiosk id, double flag}; storage needs no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      q_mem[wr_ptr] <= {grant_idx, req_double[grant_idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      rr_req      <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_req <= (grant_idx == REQ_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= D_IDLE;
      sel_q       <= '0;
      rr_mach     <= '0;
      mach_busy   <= '0;
      mach_double <= '0;
      mach_coin   <= '0;
      ack_valid   <= 1'b0;
      ack_req_id  <= '0;
      ack_mach_id <= '0;
    end else begin
      // Done only matters for allocated machines; the later bit-set below wins on a collision.
      mach_busy   <= mach_busy & ~mach_wash_done;
      mach_double <= mach_double & ~(mach_busy & mach_wash_done);
      mach_coin   <= '0;
      ack_valid   <= 1'b0;
      case (state)
        D_IDLE: begin
          if ((queue_count != '0) && sel_found) begin
            sel_q                <= sel_idx;
            mach_double[sel_idx] <= head[0];
            mach_coin[sel_idx]   <= 1'b1;
            ack_valid            <= 1'b1;
            ack_req_id           <= head[REQ_W:1];
            ack_mach_id          <= sel_idx;
            state                <= D_ISSUE;
          end
        end
        D_ISSUE: begin
          mach_busy[sel_q] <= 1'b1;
          rr_mach          <= (sel_q == MACH_W'(NUM_MACH-1)) ? '0 : sel_q + 1'b1;
          state            <= D_GAP;
        end
        D_GAP:   state <= D_IDLE;
        default: state <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && (state == D_ISSUE))
      assert (!(mach_busy[sel_q] && mach_wash_done[sel_q]));
  end

endmodule

// File: tb/tb_wash_dispatcher.sv
// Directed bench for wash_dispatcher: inputs driven 1 ns after the rising edge,
// outputs checked 1-2 ns later within the same cycle.
module tb_wash_dispatcher;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_double;
  logic [3:0] req_ready;
  logic [3:0] mach_wash_done;
  logic [3:0] mach_disable;
  logic [3:0] mach_coin;
  logic [3:0] mach_double;
  logic [3:0] mach_busy;
  logic       ack_valid;
  logic [1:0] ack_req_id;
  logic [1:0] ack_mach_id;
  logic [2:0] queue_count;

  int n_assert = 0;
  int n_fail   = 0;

  wash_dispatcher #(
    .NUM_REQ (4),
    .NUM_MACH(4),
    .QDEPTH  (4),
    .REQ_W   (2),
    .MACH_W  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_double    (req_double),
    .req_ready     (req_ready),
    .mach_wash_done(mach_wash_done),
    .mach_disable  (mach_disable),
    .mach_coin     (mach_coin),
    .mach_double   (mach_double),
    .mach_busy     (mach_busy),
    .ack_valid     (ack_valid),
    .ack_req_id    (ack_req_id),
    .ack_mach_id   (ack_mach_id),
    .queue_count   (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dispatch(input string tag, input logic [3:0] coin, input logic [1:0] rid,
                              input logic [1:0] mid);
    chk({tag, "_coin"}, 32'(mach_coin), 32'(coin));
    chk({tag, "_ackv"}, 32'(ack_valid), 32'h1);
    chk({tag, "_ackreq"}, 32'(ack_req_id), 32'(rid));
    chk({tag, "_ackmach"}, 32'(ack_mach_id), 32'(mid));
  endtask

  // Leaves the bench 1 ns into the first cycle after reset release (cycle C0).
  task automatic do_reset();
    rst_n          = 1'b0;
    req_valid      = '0;
    req_double     = '0;
    mach_wash_done = '0;
    mach_disable   = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_coin;
  logic [3:0] exp_ready;

  initial begin
    // ---------------- single double-wash order from kiosk 2
    do_reset();
    cyc();
    chk("rst_qcount", 32'(queue_count), 32'h0);
    chk("rst_busy", 32'(mach_busy), 32'h0);
    chk("rst_coin", 32'(mach_coin), 32'h0);
    chk("rst_double", 32'(mach_double), 32'h0);
    chk("rst_ackv", 32'(ack_valid), 32'h0);
    chk("rst_ackreq", 32'(ack_req_id), 32'h0);
    req_valid  = 4'b0100;
    req_double = 4'b0100;
    #1;
    chk("t1_ready_c0", 32'(req_ready), 32'h4);
    cyc();                                    // C1
    req_valid = '0;
    chk("t1_qcount_c1", 32'(queue_count), 32'h1);
    chk("t1_coin_c1", 32'(mach_coin), 32'h0);
    cyc();                                    // C2
    chk_dispatch("t1_c2", 4'b0001, 2'd2, 2'd0);
    chk("t1_double_c2", 32'(mach_double), 32'h1);
    cyc();                                    // C3
    chk("t1_busy_c3", 32'(mach_busy), 32'h1);
    chk("t1_coin_c3", 32'(mach_coin), 32'h0);
    chk("t1_ackv_c3", 32'(ack_valid), 32'h0);
    chk("t1_qcount_c3", 32'(queue_count), 32'h0);
    mach_wash_done = 4'b1000;                 // done on an idle machine
    cyc();
    mach_wash_done = 4'b0001;
    chk("t1_idle_done_busy", 32'(mach_busy), 32'h1);
    chk("t1_idle_done_double", 32'(mach_double), 32'h1);
    cyc();
    mach_wash_done = '0;
    chk("t1_release_busy", 32'(mach_busy), 32'h0);
    chk("t1_release_double", 32'(mach_double), 32'h0);

    // ---------------- four kiosks at once, dispatch every third cycle
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) cyc();
      req_valid = (c < 4) ? 4'(4'b1111 << c) : 4'b0000;
      exp_ready = (c < 4) ? 4'(4'b0001 << c) : 4'b0000;
      exp_coin  = (c >= 2 && ((c - 2) % 3) == 0) ? 4'(1 << ((c - 2) / 3)) : 4'b0000;
      #1;
      chk($sformatf("t2_ready_c%0d", c), 32'(req_ready), 32'(exp_ready));
      chk($sformatf("t2_coin_c%0d", c), 32'(mach_coin), 32'(exp_coin));
      if (exp_coin != 4'b0000) begin
        chk($sformatf("t2_ackreq_c%0d", c), 32'(ack_req_id), 32'((c - 2) / 3));
        chk($sformatf("t2_ackmach_c%0d", c), 32'(ack_mach_id), 32'((c - 2) / 3));
      end
    end
    chk("t2_busy_all", 32'(mach_busy), 32'hF);
    chk("t2_qcount_end", 32'(queue_count), 32'h0);

    // ---------------- all machines busy, freed machine 2 is picked over rr_mach=0
    cyc();                                    // D0
    req_valid = 4'b0011;
    #1;
    chk("t4_ready_d0", 32'(req_ready), 32'h1);
    cyc();                                    // D1
    req_valid = 4'b0010;
    #1;
    chk("t4_ready_d1", 32'(req_ready), 32'h2);
    cyc();                                    // D2
    req_valid = '0;
    chk("t4_qcount_d2", 32'(queue_count), 32'h2);
    cyc();                                    // D3
    chk("t4_qcount_d3", 32'(queue_count), 32'h2);
    chk("t4_coin_d3", 32'(mach_coin), 32'h0);
    mach_wash_done = 4'b0100;
    cyc();                                    // D4
    mach_wash_done = '0;
    chk("t4_busy_d4", 32'(mach_busy), 32'hB);
    chk("t4_coin_d4", 32'(mach_coin), 32'h0);
    cyc();                                    // D5
    chk_dispatch("t4_d5", 4'b0100, 2'd0, 2'd2);
    cyc();                                    // D6
    chk("t4_busy_d6", 32'(mach_busy), 32'hF);
    chk("t4_qcount_d6", 32'(queue_count), 32'h1);

    // ---------------- all disabled: queue fills, then enable/disable interplay
    do_reset();
    mach_disable = 4'b1111;
    req_valid    = 4'b1111;
    #1;
    chk("t3_ready_c0", 32'(req_ready), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      req_valid = 4'(4'b1111 << c);
    end
    cyc();                                    // C4
    req_valid  = 4'b0001;
    req_double = 4'b0001;
    #1;
    chk("t3_ready_full_c4", 32'(req_ready), 32'h0);
    chk("t3_qcount_c4", 32'(queue_count), 32'h4);
    cyc();                                    // C5
    mach_disable = 4'b1101;
    #1;
    chk("t3_ready_c5", 32'(req_ready), 32'h0);
    chk("t3_coin_c5", 32'(mach_coin), 32'h0);
    cyc();                                    // C6
    chk_dispatch("t3_c6", 4'b0010, 2'd0, 2'd1);
    chk("t3_ready_c6", 32'(req_ready), 32'h0);
    chk("t3_qcount_c6", 32'(queue_count), 32'h4);
    cyc();                                    // C7
    chk("t3_qcount_c7", 32'(queue_count), 32'h3);
    chk("t3_ready_c7", 32'(req_ready), 32'h1);
    chk("t3_busy_c7", 32'(mach_busy), 32'h2);
    cyc();                                    // C8
    req_valid    = '0;
    req_double   = '0;
    mach_disable = 4'b1111;
    chk("t3_qcount_c8", 32'(queue_count), 32'h4);
    cyc();                                    // C9
    chk("t6_busy_dis_c9", 32'(mach_busy), 32'h2);
    cyc();                                    // C10
    chk("t6_busy_dis_c10", 32'(mach_busy), 32'h2);
    mach_wash_done = 4'b0010;
    cyc();                                    // C11
    mach_wash_done = '0;
    chk("t6_busy_c11", 32'(mach_busy), 32'h0);
    chk("t6_coin_c11", 32'(mach_coin), 32'h0);
    chk("t6_qcount_c11", 32'(queue_count), 32'h4);
    mach_disable = 4'b0010;
    cyc();                                    // C12
    chk_dispatch("t6_c12", 4'b0100, 2'd1, 2'd2);
    repeat (3) cyc();                         // C15
    chk_dispatch("t6_c15", 4'b1000, 2'd2, 2'd3);
    repeat (3) cyc();                         // C18
    chk_dispatch("t6_c18", 4'b0001, 2'd3, 2'd0);
    cyc();                                    // C19
    chk("t6_busy_c19", 32'(mach_busy), 32'hD);
    cyc();                                    // C20
    req_valid = 4'b0110;
    chk("t6_qcount_c20", 32'(queue_count), 32'h1);
    chk("t6_coin_c20", 32'(mach_coin), 32'h0);
    cyc();                                    // C21
    req_valid      = 4'b0100;
    mach_wash_done = 4'b0001;
    chk("t6_coin_c21", 32'(mach_coin), 32'h0);
    chk("t6_qcount_c21", 32'(queue_count), 32'h2);
    cyc();                                    // C22
    req_valid      = '0;
    mach_wash_done = '0;
    chk("t6_busy_c22", 32'(mach_busy), 32'hC);
    chk("t6_qcount_c22", 32'(queue_count), 32'h3);
    cyc();                                    // C23: machine 1 skipped although rr_mach=1
    chk_dispatch("t6_c23", 4'b0001, 2'd0, 2'd0);
    chk("t6_double_c23", 32'(mach_double), 32'h1);

    // ---------------- async reset in the middle of D_ISSUE
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_coin_async", 32'(mach_coin), 32'h0);
    chk("t5_ackv_async", 32'(ack_valid), 32'h0);
    chk("t5_qcount_async", 32'(queue_count), 32'h0);
    cyc();
    chk("t5_busy_rst", 32'(mach_busy), 32'h0);
    rst_n        = 1'b1;
    mach_disable = '0;
    req_valid    = 4'b1000;
    #1;
    chk("t5_ready_r0", 32'(req_ready), 32'h8);
    cyc();
    req_valid = '0;
    chk("t5_qcount_r1", 32'(queue_count), 32'h1);
    cyc();
    chk_dispatch("t5_r2", 4'b0001, 2'd3, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
